// File: rtl/axi4_duth_noc_pkg.sv
// Shared NoC link constants: default credit depth matches the router receiver buffers.
package axi4_duth_noc_pkg;
  localparam int unsigned LINK_CREDITS    = 3;
  localparam int unsigned LINK_N_REQ      = 4;
  localparam int unsigned LINK_FLIT_WIDTH = 16;
endpackage

// File: rtl/link_credit_arbiter_if.sv
// Requester/link bundle for link_credit_arbiter; slave is the arbiter's view.
interface link_credit_arbiter_if
  import axi4_duth_noc_pkg::*;
#(
  parameter int unsigned N_REQ      = LINK_N_REQ,
  parameter int unsigned LINK_WIDTH = LINK_FLIT_WIDTH,
  parameter int unsigned CREDITS    = LINK_CREDITS
) ();
  logic [N_REQ-1:0][LINK_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [LINK_WIDTH-1:0]            data_out;
  logic                             valid_out;
  logic                             cr_upd_in;
  logic [$clog2(CREDITS+1)-1:0]     credits_avail;
  logic                             cr_err;

  modport slave (
    input  req_data, req_valid, cr_upd_in,
    output req_ready, data_out, valid_out, credits_avail, cr_err
  );

  modport master (
    output req_data, req_valid, cr_upd_in,
    input  req_ready, data_out, valid_out, credits_avail, cr_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: highest priority at index ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic found;

  // Two ascending passes (i >= ptr, then the rest) keep every index constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/link_credit_arbiter.sv
// Credit-gated round-robin mux of N_REQ requesters onto one registered link.
module link_credit_arbiter
  import axi4_duth_noc_pkg::*;
#(
  parameter int unsigned N_REQ      = LINK_N_REQ,
  parameter int unsigned LINK_WIDTH = LINK_FLIT_WIDTH,
  parameter int unsigned CREDITS    = LINK_CREDITS
) (
  input logic                  clk,
  input logic                  rst,
  link_credit_arbiter_if.slave bus
);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic [CW-1:0]         cnt;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         grant_idx;
  logic [N_REQ-1:0]      req_eff;
  logic [N_REQ-1:0]      grant;
  logic [LINK_WIDTH-1:0] grant_data;
  logic [LINK_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  transfer;

  // Grant depends on the registered count only, never on this cycle's credit return.
  assign req_eff = (cnt != '0) ? bus.req_valid : '0;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_eff),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = PW'(i);
        grant_data = bus.req_data[i];
      end
    end
  end

  assign transfer          = |grant;
  assign bus.req_ready     = rst ? grant : '0;
  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.credits_avail = cnt;
  assign bus.cr_err        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= CW'(CREDITS);
      ptr     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= transfer;
      if (transfer) begin
        data_q <= grant_data;
        ptr    <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
      end
      if (transfer && !bus.cr_upd_in) begin
        cnt <= cnt - CW'(1);
      end else if (!transfer && bus.cr_upd_in) begin
        if (cnt == CW'(CREDITS)) err_q <= 1'b1;
        else                     cnt   <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_link_credit_arbiter.sv
// Directed bench for link_credit_arbiter with a cycle-level credit/round-robin model.
module tb_link_credit_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CR = 3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  link_credit_arbiter_if #(.N_REQ(N), .LINK_WIDTH(W), .CREDITS(CR)) bus ();

  link_credit_arbiter #(.N_REQ(N), .LINK_WIDTH(W), .CREDITS(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, in reset condition from time 0.
  int       m_cnt   = CR;
  int       m_ptr   = 0;
  logic     m_err   = 1'b0;
  logic     m_valid = 1'b0;
  logic [W-1:0] m_data = '0;

  function automatic int exp_idx();
    if (!rst || m_cnt == 0) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = exp_idx();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = CR; m_ptr = 0; m_err = 1'b0; m_valid = 1'b0; m_data = '0;
    end else begin
      int g;
      g = exp_idx();
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = bus.req_data[g];
        m_ptr  = (g + 1) % N;
      end
      if (bus.cr_upd_in && g < 0 && m_cnt == CR) m_err = 1'b1;
      else m_cnt = m_cnt - ((g >= 0) ? 1 : 0) + (bus.cr_upd_in ? 1 : 0);
    end
  end

  always @(negedge clk) begin
    check("model_req_ready", 32'(bus.req_ready), 32'(exp_ready()));
    check("model_valid_out", 32'(bus.valid_out), 32'(m_valid));
    check("model_data_out",  32'(bus.data_out),  32'(m_data));
    check("model_credits",   32'(bus.credits_avail), 32'(m_cnt));
    check("model_cr_err",    32'(bus.cr_err),    32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) bus.req_data[i] = base + W'(i);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.cr_upd_in = 1'b0;
    set_data(16'hA000);

    // Reset state, with requests pending to show req_ready is forced low
    bus.req_valid = '1;
    tick(); tick(); #2;
    check("rst_ready",   32'(bus.req_ready), 32'h0);
    check("rst_valid",   32'(bus.valid_out), 32'h0);
    check("rst_data",    32'(bus.data_out), 32'h0);
    check("rst_credits", 32'(bus.credits_avail), 32'd3);
    check("rst_err",     32'(bus.cr_err), 32'h0);

    // Three back-to-back grants drain the credits
    tick(); rst = 1'b1; #2;
    check("s1_ready0", 32'(bus.req_ready), 32'b0001);
    tick(); #2;
    check("s1_data0",  32'(bus.data_out), 32'hA000);
    check("s1_valid0", 32'(bus.valid_out), 32'h1);
    check("s1_cred2",  32'(bus.credits_avail), 32'd2);
    check("s1_ready1", 32'(bus.req_ready), 32'b0010);
    tick(); #2;
    check("s1_data1",  32'(bus.data_out), 32'hA001);
    check("s1_cred1",  32'(bus.credits_avail), 32'd1);
    check("s1_ready2", 32'(bus.req_ready), 32'b0100);
    tick(); #2;
    check("s1_data2",  32'(bus.data_out), 32'hA002);
    check("s1_valid2", 32'(bus.valid_out), 32'h1);
    check("s1_cred0",  32'(bus.credits_avail), 32'd0);
    check("s1_ready_none", 32'(bus.req_ready), 32'b0000);
    tick(); #2;
    check("s1_valid_off", 32'(bus.valid_out), 32'h0);
    check("s1_data_hold", 32'(bus.data_out), 32'hA002);

    // Credit return with cnt=0: no bypass, grant next cycle to requester 3
    bus.cr_upd_in = 1'b1; #1;
    check("s2_no_bypass", 32'(bus.req_ready), 32'b0000);
    tick(); bus.cr_upd_in = 1'b0; #2;
    check("s2_cred1",  32'(bus.credits_avail), 32'd1);
    check("s2_ready3", 32'(bus.req_ready), 32'b1000);
    tick(); #2;
    check("s2_cred0",  32'(bus.credits_avail), 32'd0);
    check("s2_data3",  32'(bus.data_out), 32'hA003);

    // Simultaneous transfer and credit return at cnt=2
    bus.req_valid = '0; bus.cr_upd_in = 1'b1;
    tick(); tick();
    set_data(16'hB000); bus.req_valid = '1; #2;
    check("s3_cred2_pre", 32'(bus.credits_avail), 32'd2);
    check("s3_ready0",    32'(bus.req_ready), 32'b0001);
    tick(); bus.cr_upd_in = 1'b0; bus.req_valid = '0; #2;
    check("s3_cred2_post", 32'(bus.credits_avail), 32'd2);
    check("s3_data",       32'(bus.data_out), 32'hB000);

    // Wrap: only requester 1 valid while ptr=2; ptr lands back on 2
    bus.req_valid = 4'b0010; #2;
    check("s4_ready1a", 32'(bus.req_ready), 32'b0010);
    tick(); #2;
    check("s4_ready1_wrap", 32'(bus.req_ready), 32'b0010);
    tick(); bus.req_valid = '0; #2;
    check("s4_cred0", 32'(bus.credits_avail), 32'd0);
    check("s4_data",  32'(bus.data_out), 32'hB001);
    bus.cr_upd_in = 1'b1;
    tick(); bus.cr_upd_in = 1'b0; bus.req_valid = '1; #2;
    check("s4_ptr2", 32'(bus.req_ready), 32'b0100);
    tick(); bus.req_valid = '0;

    // Spurious credit at full count: saturate and set sticky error
    bus.cr_upd_in = 1'b1;
    tick(); tick(); tick(); #2;
    check("s5_cred_full", 32'(bus.credits_avail), 32'd3);
    check("s5_err_clear", 32'(bus.cr_err), 32'h0);
    tick(); bus.cr_upd_in = 1'b0; #2;
    check("s5_cred_sat", 32'(bus.credits_avail), 32'd3);
    check("s5_err_set",  32'(bus.cr_err), 32'h1);
    tick(); tick(); #2;
    check("s5_err_sticky", 32'(bus.cr_err), 32'h1);

    // Asynchronous reset mid-stream
    bus.req_valid = '1;
    tick(); #2;
    check("s6_valid_pre", 32'(bus.valid_out), 32'h1);
    rst = 1'b0; #1;
    check("s6_valid_async", 32'(bus.valid_out), 32'h0);
    check("s6_cred_async",  32'(bus.credits_avail), 32'd3);
    check("s6_err_async",   32'(bus.cr_err), 32'h0);
    check("s6_data_async",  32'(bus.data_out), 32'h0);
    check("s6_ready_async", 32'(bus.req_ready), 32'h0);
    tick(); rst = 1'b1; #2;
    check("s6_ready_after", 32'(bus.req_ready), 32'b0001);
    tick(); #2;
    check("s6_data_after", 32'(bus.data_out), 32'hB000);

    bus.req_valid = '0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/link_credit_arbiter.md
LINK_CREDIT_ARBITER -- requirements
Module: link_credit_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one outgoing link (range 2..16).
REQ-002 The block SHALL have parameter LINK_WIDTH, default 16, giving the flit width in bits.
REQ-003 The block SHALL have parameter CREDITS, default 3, giving the downstream receiver buffer depth (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-006 The block SHALL have port req_data, input, N_REQ x LINK_WIDTH bits: the flit offered by each requester.
REQ-007 The block SHALL have port req_valid, input, N_REQ bits: per-requester flit-valid.
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: per-requester grant/accept, at most one bit high.
REQ-009 The block SHALL have port data_out, output, LINK_WIDTH bits: registered link data.
REQ-010 The block SHALL have port valid_out, output, 1 bit: registered link valid, with a one-cycle pulse per flit.
REQ-011 The block SHALL have port cr_upd_in, input, 1 bit: credit-return pulse from the downstream receiver; each high cycle returns one credit.
REQ-012 The block SHALL have port credits_avail, output, $clog2(CREDITS+1) bits: current credit count.
REQ-013 The block SHALL have port cr_err, output, 1 bit: sticky credit-overflow error.

Function
REQ-014 The block SHALL hold a credit counter cnt, initialised to CREDITS; credits_avail SHALL equal cnt.
REQ-015 Grant SHALL be allowed only when cnt > 0, using the registered cnt; a cr_upd_in in the same cycle SHALL NOT enable a grant (no bypass).
REQ-016 When grant is allowed, the block SHALL grant exactly one requester with req_valid=1, selected round-robin starting at index ptr and wrapping N_REQ-1 -> 0.
REQ-017 req_ready[i] SHALL be combinational and equal to grant[i]; req_ready SHALL be all zero when cnt = 0 or no req_valid is high.
REQ-018 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-019 On a transfer, the next cycle SHALL have valid_out=1 and data_out=req_data[i] (latency 1); in cycles without a transfer, valid_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-020 On a transfer from requester i, ptr SHALL become (i+1) mod N_REQ; without a transfer, ptr SHALL be unchanged.
REQ-021 cnt update rule: cnt_next = cnt - transfer + cr_upd_in; a simultaneous transfer and cr_upd_in SHALL leave cnt unchanged.
REQ-022 If cr_upd_in=1, there is no transfer and cnt = CREDITS, then cnt SHALL saturate at CREDITS and cr_err SHALL set and stay at 1 until reset.
REQ-023 cnt SHALL never underflow; this holds by construction of REQ-015.
REQ-024 A requester that drops req_valid without a transfer SHALL lose nothing; ptr is unaffected.
REQ-025 Sustained throughput SHALL be one flit per cycle while cnt > 0 and requests are present.

Reset
REQ-026 While rst=0, the block SHALL force valid_out=0, data_out=0, cnt=CREDITS, ptr=0, cr_err=0 and req_ready=0, asynchronously.
REQ-027 On the first clk edge after rst deasserts, the block SHALL be able to grant.
REQ-028 Reset asserted mid-transfer SHALL discard the in-flight registered flit; the bench SHALL re-synchronise the downstream receiver on the same reset.

Structure
REQ-029 The default credit depth SHALL be a constant in axi4_duth_noc_pkg, sized to match the receiver credit configuration (3 for router links); no new typedefs are required.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and ptr; output: one-hot grant); the counter and output register SHALL stay in link_credit_arbiter.
REQ-031 The design SHALL contain no combinational path from cr_upd_in to req_ready.

Verification
REQ-032 Scenario: CREDITS=3, N_REQ=4, all req_valid=1, no cr_upd_in -> grants go to 0,1,2 on three consecutive cycles, then req_ready=0, credits_avail=0, and valid_out pulses three times, each one cycle after its grant.
REQ-033 Scenario: cnt=0 and cr_upd_in pulsed in cycle t -> no grant in cycle t; grant in t+1 to requester 3; credits_avail 0->1->0.
REQ-034 Scenario: cnt=2 with a transfer and cr_upd_in in the same cycle -> credits_avail stays 2; data_out matches the granted requester's flit.
REQ-035 Scenario: only requester 1 is valid while ptr=2 -> the grant wraps to requester 1 and ptr becomes 2.
REQ-036 Scenario: cnt=3 and a spurious cr_upd_in -> credits_avail stays 3, cr_err=1 persists, and cr_err clears only on rst=0.
REQ-037 Scenario: rst driven low asynchronously mid-stream -> valid_out=0 and credits_avail=3 immediately, without waiting for clk.
